wbm_uart_cmd: RTL

//  Byte-stream-to-Wishbone command bridge, downstream of the UART receiver and upstream of the UART transmitter.
//  - Consumes received bytes, decodes read/write commands and issues single Wishbone B4 pipelined master cycles.
//  - Returns the response as bytes to the transmitter.
//  - Gives a host PC register access to the SoC over the serial link.

---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/wbm_uart_cmd_if.sv | 24 ++
 rtl/uart_cmd_timer.sv | 35 +++
 rtl/wbm_uart_cmd.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the UART command bridge.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h2B;
  localparam logic [7:0] RSP_ERR = 8'h21;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBus,
    StResp
  } state_e;

endpackage

// File: rtl/wbm_uart_cmd_if.sv
// Wishbone B4 pipelined single-master bus bundle.
interface wbm_uart_cmd_if #(
  parameter int unsigned ADR_W = 4
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_m2s;
  logic [3:0]       sel;
  logic [31:0]      dat_s2m;
  logic             ack;
  logic             stall;

  modport master (
    output cyc, stb, we, adr, dat_m2s, sel,
    input  dat_s2m, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_m2s, sel,
    output dat_s2m, ack, stall
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Saturating cycle counter; expired_o flags the counted cycle that reaches Limit.
module uart_cmd_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntW'(Limit))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q >= CntW'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wbm_uart_cmd.sv
// Byte-stream command decoder issuing single Wishbone pipelined cycles and
// returning the response bytes to the UART transmitter.
module wbm_uart_cmd
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADR_W        = 4,
  parameter int unsigned BUS_TIMEOUT  = 255,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [7:0]            rx_dat_i,
  input  logic                  rx_stb_i,
  output logic [7:0]            tx_dat_o,
  output logic                  tx_stb_o,
  input  logic                  tx_rdy_i,
  wbm_uart_cmd_if.master        wbm,
  output logic                  err_o
);

  state_e           state_q;
  logic             we_q;
  logic [ADR_W-1:0] adr_q;
  logic [31:0]      dat_q;
  logic [1:0]       cnt_q;
  logic             cyc_q;
  logic             stb_q;
  logic [31:0]      rsp_q;
  logic [1:0]       rsp_last_q;
  logic [1:0]       idx_q;
  logic             tx_stb_q;
  logic             err_q;

  logic idle_active;
  logic idle_expired;
  logic bus_expired;

  assign idle_active = (state_q == StAddr) || (state_q == StData);

  // Any received byte restarts the inter-byte gap measurement.
  uart_cmd_timer #(
    .Limit(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clr_i    (!idle_active || rx_stb_i),
    .en_i     (idle_active && !rx_stb_i),
    .expired_o(idle_expired)
  );

  uart_cmd_timer #(
    .Limit(BUS_TIMEOUT)
  ) u_bus_timer (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .clr_i    (state_q != StBus),
    .en_i     (state_q == StBus),
    .expired_o(bus_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      rsp_q      <= '0;
      rsp_last_q <= '0;
      idx_q      <= '0;
      tx_stb_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_stb_i && ((rx_dat_i == CMD_WR) || (rx_dat_i == CMD_RD))) begin
            we_q    <= (rx_dat_i == CMD_WR);
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (rx_stb_i) begin
            adr_q <= rx_dat_i[ADR_W-1:0];
            if (we_q) begin
              cnt_q   <= '0;
              state_q <= StData;
            end else begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= StBus;
            end
          end else if (idle_expired) begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (rx_stb_i) begin
            dat_q <= {dat_q[23:0], rx_dat_i};
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              state_q <= StBus;
            end
          end else if (idle_expired) begin
            state_q <= StIdle;
          end
        end
        StBus: begin
          if (rx_stb_i) begin
            err_q <= 1'b1;
          end
          if (stb_q && !wbm.stall) begin
            stb_q <= 1'b0;
          end
          // An ack in the timeout cycle still wins over the abort.
          if (wbm.ack) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            idx_q    <= '0;
            tx_stb_q <= 1'b1;
            state_q  <= StResp;
            if (we_q) begin
              rsp_q      <= {RSP_OK, 24'h0};
              rsp_last_q <= 2'd0;
            end else begin
              rsp_q      <= wbm.dat_s2m;
              rsp_last_q <= 2'd3;
            end
          end else if (bus_expired) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            err_q      <= 1'b1;
            rsp_q      <= {RSP_ERR, 24'h0};
            rsp_last_q <= 2'd0;
            idx_q      <= '0;
            tx_stb_q   <= 1'b1;
            state_q    <= StResp;
          end
        end
        StResp: begin
          if (rx_stb_i) begin
            err_q <= 1'b1;
          end
          if (tx_stb_q && tx_rdy_i) begin
            if (idx_q == rsp_last_q) begin
              tx_stb_q <= 1'b0;
              state_q  <= StIdle;
            end else begin
              idx_q <= idx_q + 2'd1;
              rsp_q <= {rsp_q[23:0], 8'h00};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wbm.cyc     = cyc_q;
  assign wbm.stb     = stb_q;
  assign wbm.we      = we_q;
  assign wbm.adr     = adr_q;
  assign wbm.dat_m2s = dat_q;
  assign wbm.sel     = cyc_q ? 4'hF : 4'h0;

  assign tx_stb_o = tx_stb_q;
  assign tx_dat_o = tx_stb_q ? rsp_q[31:24] : 8'h00;
  assign err_o    = err_q;

endmodule
